// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between the instruction-fetch
// (IF) port and the memory-access (MA) port. Round-robin grant, one transaction
// outstanding at a time, fixed read latency.
//
// Requester handshake: a requester raises req with address (and write data) and
// holds them stable until its ready pulses for exactly one cycle; rdata is valid
// in that cycle and holds until that port's next read completes. A req still
// high in the IDLE cycle after ready starts a new transaction.
module memory_arbiter #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  ma_req,
   input  logic                  ma_we,
   input  logic [ADDR_WIDTH-1:0] ma_addr,
   input  logic [DATA_WIDTH-1:0] ma_wdata,
   output logic                  ma_ready,
   output logic [DATA_WIDTH-1:0] ma_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0] state;
   logic       owner_ma;   // 1 = MA owns the current transaction, 0 = IF
   logic       lat_we;     // latched write flag of the current transaction
   logic       prio_ma;    // 1 = MA wins a tie in IDLE
   logic [3:0] cnt;        // read-latency down-counter
   logic       grant_any;
   logic       grant_ma;

   // Round-robin grant decision, only consumed in IDLE.
   always_comb begin
      grant_any = if_req | ma_req;
      grant_ma  = 1'b0;
      if (ma_req && (!if_req || prio_ma)) begin
         grant_ma = 1'b1;
      end
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         owner_ma  <= 1'b0;
         lat_we    <= 1'b0;
         prio_ma   <= 1'b1;
         cnt       <= 4'd0;
         if_ready  <= 1'b0;
         if_rdata  <= '0;
         ma_ready  <= 1'b0;
         ma_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         // Ready outputs are single-cycle pulses.
         if_ready <= 1'b0;
         ma_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  state    <= S_ISSUE;
                  busy     <= 1'b1;
                  owner_ma <= grant_ma;
                  // Point at the requester that lost (or did not ask).
                  prio_ma  <= ~grant_ma;
                  lat_we   <= grant_ma & ma_we;
                  // Memory command is registered so it appears in ISSUE.
                  mem_en   <= 1'b1;
                  mem_we   <= grant_ma & ma_we;
                  mem_addr <= grant_ma ? ma_addr : if_addr;
                  mem_wdata <= (grant_ma && ma_we) ? ma_wdata : '0;
               end
            end
            S_ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (lat_we) begin
                  // Only MA can write, so the write completes on MA.
                  state    <= S_RESP;
                  ma_ready <= owner_ma;
                  if_ready <= ~owner_ma;
               end else begin
                  cnt   <= 4'(MEM_LATENCY);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  // Last wait cycle: memory data is valid now.
                  if (owner_ma) begin
                     ma_rdata <= mem_rdata;
                     ma_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               // Ready is high this cycle; requests are not looked at.
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at MEM_LATENCY=2, one at
// MEM_LATENCY=1, each with a small behavioural memory that presents read data
// only in the exact cycle the arbiter should sample it.
module tb_memory_arbiter;

   logic        clk;
   logic        reset;

   // Instance 1 (MEM_LATENCY = 2)
   logic        if_req, ma_req, ma_we;
   logic [15:0] if_addr, ma_addr, ma_wdata;
   logic        if_ready, ma_ready, mem_en, mem_we, busy;
   logic [15:0] if_rdata, ma_rdata, mem_addr, mem_wdata, mem_rdata;

   // Instance 2 (MEM_LATENCY = 1)
   logic        if_req2, ma_req2, ma_we2;
   logic [15:0] if_addr2, ma_addr2, ma_wdata2;
   logic        if_ready2, ma_ready2, mem_en2, mem_we2, busy2;
   logic [15:0] if_rdata2, ma_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

   int n_cmp;
   int n_err;
   logic [31:0] exp_q[$];

   memory_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
      .ma_ready(ma_ready), .ma_rdata(ma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   memory_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .if_req(if_req2), .if_addr(if_addr2), .if_ready(if_ready2), .if_rdata(if_rdata2),
      .ma_req(ma_req2), .ma_we(ma_we2), .ma_addr(ma_addr2), .ma_wdata(ma_wdata2),
      .ma_ready(ma_ready2), .ma_rdata(ma_rdata2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .busy(busy2)
   );

   // Clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory contents: one special word, everything else derived from address.
   function automatic logic [15:0] data_of(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   // Behavioural memory, latency 2: data valid only in issue+2.
   logic [3:0]  rd_cnt;
   logic [15:0] rd_val;
   always @(posedge clk) begin
      if (reset) begin
         rd_cnt <= 4'd0;
      end else if (mem_en && !mem_we) begin
         rd_cnt <= 4'd2;
         rd_val <= data_of(mem_addr);
      end else if (rd_cnt != 4'd0) begin
         rd_cnt <= rd_cnt - 4'd1;
      end
   end
   assign mem_rdata = (rd_cnt == 4'd1) ? rd_val : 16'hDEAD;

   // Behavioural memory, latency 1: data valid only in issue+1.
   logic [3:0]  rd_cnt2;
   logic [15:0] rd_val2;
   always @(posedge clk) begin
      if (reset) begin
         rd_cnt2 <= 4'd0;
      end else if (mem_en2 && !mem_we2) begin
         rd_cnt2 <= 4'd1;
         rd_val2 <= data_of(mem_addr2);
      end else if (rd_cnt2 != 4'd0) begin
         rd_cnt2 <= rd_cnt2 - 4'd1;
      end
   end
   assign mem_rdata2 = (rd_cnt2 == 4'd1) ? rd_val2 : 16'hDEAD;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic randomize_inputs();
      if_req   = 1'($urandom_range(0, 1));
      if_addr  = 16'($urandom_range(0, 65535));
      ma_req   = 1'($urandom_range(0, 1));
      ma_we    = 1'($urandom_range(0, 1));
      ma_addr  = 16'($urandom_range(0, 65535));
      ma_wdata = 16'($urandom_range(0, 65535));
      if_req2  = 1'($urandom_range(0, 1));
      if_addr2 = 16'($urandom_range(0, 65535));
      ma_req2  = 1'($urandom_range(0, 1));
      ma_we2   = 1'($urandom_range(0, 1));
      ma_addr2 = 16'($urandom_range(0, 65535));
      ma_wdata2 = 16'($urandom_range(0, 65535));
   endtask

   task automatic clear_inputs();
      if_req = 0; if_addr = 0; ma_req = 0; ma_we = 0; ma_addr = 0; ma_wdata = 0;
      if_req2 = 0; if_addr2 = 0; ma_req2 = 0; ma_we2 = 0; ma_addr2 = 0; ma_wdata2 = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_en"}, 32'(mem_en), 0);
      check({tag, "_mem_we"}, 32'(mem_we), 0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      check({tag, "_if_ready"}, 32'(if_ready), 0);
      check({tag, "_ma_ready"}, 32'(ma_ready), 0);
      check({tag, "_if_rdata"}, 32'(if_rdata), 0);
      check({tag, "_ma_rdata"}, 32'(ma_rdata), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   int seen;
   logic [31:0] exp_owner;

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Reset held two cycles with random inputs
      reset = 1'b1;
      randomize_inputs();
      tick();
      randomize_inputs();
      tick();
      check_all_zero("reset");
      check("reset_l1_busy", 32'(busy2), 0);
      check("reset_l1_mem_en", 32'(mem_en2), 0);
      reset = 1'b0;
      clear_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("idle_c%0d_mem_en", k), 32'(mem_en), 0);
         check($sformatf("idle_c%0d_busy", k), 32'(busy), 0);
      end

      // IF read at 0x0040, memory returns 0xBEEF in cycle 3
      if_req  = 1'b1;
      if_addr = 16'h0040;
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("ifrd_c%0d_mem_en", k), 32'(mem_en), 32'(k == 1));
         check($sformatf("ifrd_c%0d_if_ready", k), 32'(if_ready), 32'(k == 4));
         check($sformatf("ifrd_c%0d_ma_ready", k), 32'(ma_ready), 0);
         check($sformatf("ifrd_c%0d_busy", k), 32'(busy), 32'(k >= 1 && k <= 4));
         if (k == 1) begin
            check("ifrd_mem_addr", 32'(mem_addr), 32'h0040);
            check("ifrd_mem_we", 32'(mem_we), 0);
         end
         if (k == 4) begin
            check("ifrd_if_rdata", 32'(if_rdata), 32'hBEEF);
            if_req = 1'b0;
         end
         tick();
      end

      // MA write 0xA5A5 to 0x1234
      ma_req   = 1'b1;
      ma_we    = 1'b1;
      ma_addr  = 16'h1234;
      ma_wdata = 16'hA5A5;
      for (int k = 0; k <= 3; k++) begin
         check($sformatf("mawr_c%0d_mem_en", k), 32'(mem_en), 32'(k == 1));
         check($sformatf("mawr_c%0d_ma_ready", k), 32'(ma_ready), 32'(k == 2));
         check($sformatf("mawr_c%0d_if_ready", k), 32'(if_ready), 0);
         if (k == 1) begin
            check("mawr_mem_we", 32'(mem_we), 1);
            check("mawr_mem_addr", 32'(mem_addr), 32'h1234);
            check("mawr_mem_wdata", 32'(mem_wdata), 32'hA5A5);
         end
         if (k == 2) begin
            check("mawr_mem_addr_cleared", 32'(mem_addr), 0);
            check("mawr_mem_wdata_cleared", 32'(mem_wdata), 0);
            check("mawr_ma_rdata_kept", 32'(ma_rdata), 0);
            check("mawr_if_rdata_kept", 32'(if_rdata), 32'hBEEF);
            ma_req = 1'b0;
            ma_we  = 1'b0;
         end
         tick();
      end

      // Contention from reset: MA first (cycle 1..4), then IF (cycle 6..9)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ma_req  = 1'b1;
      ma_addr = 16'h0100;
      if_req  = 1'b1;
      if_addr = 16'h0200;
      for (int k = 0; k <= 10; k++) begin
         check($sformatf("cont_c%0d_mem_en", k), 32'(mem_en), 32'(k == 1 || k == 6));
         check($sformatf("cont_c%0d_ma_ready", k), 32'(ma_ready), 32'(k == 4));
         check($sformatf("cont_c%0d_if_ready", k), 32'(if_ready), 32'(k == 9));
         if (k == 1) check("cont_ma_addr", 32'(mem_addr), 32'h0100);
         if (k == 6) check("cont_if_addr", 32'(mem_addr), 32'h0200);
         if (k == 4) begin
            check("cont_ma_rdata", 32'(ma_rdata), 32'h5B5A);
            ma_req = 1'b0;
         end
         if (k == 9) begin
            check("cont_if_rdata", 32'(if_rdata), 32'h585A);
            ma_req = 1'b1;   // both now request continuously
         end
         tick();
      end

      // Continuous requesters alternate MA, IF, MA, IF (1 = MA)
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      seen = 0;
      for (int c = 0; c < 40 && seen < 4; c++) begin
         if (ma_ready || if_ready) begin
            check($sformatf("alt%0d_one_hot", seen), 32'(ma_ready & if_ready), 0);
            exp_owner = exp_q.pop_front();
            check($sformatf("alt%0d_owner_ma", seen), 32'(ma_ready), exp_owner);
            seen++;
            if (seen == 4) begin
               ma_req = 1'b0;
               if_req = 1'b0;
            end
         end
         tick();
      end
      check("alt_count", 32'(seen), 4);
      check("alt_idle_busy", 32'(busy), 0);
      tick();
      check("alt_idle_mem_en", 32'(mem_en), 0);

      // Reset in the second WAIT cycle of an IF read
      if_req  = 1'b1;
      if_addr = 16'h0010;
      for (int k = 0; k <= 3; k++) begin
         if (k == 2) check("rstmid_wait_busy", 32'(busy), 1);
         if (k == 3) begin
            reset  = 1'b1;
            if_req = 1'b0;
         end
         tick();
      end
      check_all_zero("rstmid");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("rstmid_after_c%0d_if_ready", k), 32'(if_ready), 0);
         check($sformatf("rstmid_after_c%0d_mem_en", k), 32'(mem_en), 0);
      end
      if_req  = 1'b1;
      if_addr = 16'h0002;
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("rstrd_c%0d_mem_en", k), 32'(mem_en), 32'(k == 1));
         check($sformatf("rstrd_c%0d_if_ready", k), 32'(if_ready), 32'(k == 4));
         if (k == 1) check("rstrd_mem_addr", 32'(mem_addr), 32'h0002);
         if (k == 4) begin
            check("rstrd_if_rdata", 32'(if_rdata), 32'h5A58);
            if_req = 1'b0;
         end
         tick();
      end

      // MEM_LATENCY = 1: WAIT is cycle 2 only, ready in cycle 3
      if_req2  = 1'b1;
      if_addr2 = 16'h0040;
      for (int k = 0; k <= 4; k++) begin
         check($sformatf("l1_c%0d_mem_en", k), 32'(mem_en2), 32'(k == 1));
         check($sformatf("l1_c%0d_busy", k), 32'(busy2), 32'(k >= 1 && k <= 3));
         check($sformatf("l1_c%0d_if_ready", k), 32'(if_ready2), 32'(k == 3));
         check($sformatf("l1_c%0d_ma_ready", k), 32'(ma_ready2), 0);
         if (k == 3) begin
            check("l1_if_rdata", 32'(if_rdata2), 32'hBEEF);
            if_req2 = 1'b0;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
